// File: rtl/regfile_pkg.sv
// Shared widths, counts and FSM state encoding for the register-file dump
// engine and the register file it reads.
package regfile_pkg;

    localparam int ADDR_W    = 5;
    localparam int DATA_W    = 32;
    localparam int NUM_REGS  = 32;
    localparam int NUM_PAIRS = NUM_REGS / 2;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        READ   = 3'd1,
        SEND_A = 3'd2,
        SEND_B = 3'd3,
        DONE   = 3'd4
    } state_t;

    typedef logic [ADDR_W-2:0] pair_t;

    localparam pair_t             LAST_PAIR  = pair_t'(NUM_PAIRS - 1);
    localparam logic [ADDR_W-1:0] LAST_INDEX = ADDR_W'(NUM_REGS - 1);

    // Register index of the even (odd=0) or odd (odd=1) member of pair k.
    function automatic logic [ADDR_W-1:0] pair_index(input pair_t k, input logic odd);
        return {k, odd};
    endfunction

endpackage

// File: rtl/regfile_dump_if.sv
// Valid/ready stream carrying one register index/data word per handshake.
interface regfile_dump_if;
    import regfile_pkg::*;

    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [ADDR_W-1:0] out_index;
    logic              out_last;

    modport master (
        output out_valid,
        output out_data,
        output out_index,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        input  out_index,
        input  out_last,
        output out_ready
    );

endinterface

// File: rtl/regfile_dump.sv
// Debug readout engine: reads the register file two entries at a time and
// streams every register out as an index/data word over valid/ready.
module regfile_dump
    import regfile_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] readsel1,
    output logic [ADDR_W-1:0] readsel2,
    input  logic [DATA_W-1:0] Dout1,
    input  logic [DATA_W-1:0] Dout2,
    regfile_dump_if.master    stream
);

    state_t            r_state;
    pair_t             r_k;
    logic              r_busy;
    logic              r_done;
    logic              r_out_valid;
    logic              r_out_last;
    logic [DATA_W-1:0] r_out_data;
    logic [ADDR_W-1:0] r_out_index;
    logic [ADDR_W-1:0] r_readsel1;
    logic [ADDR_W-1:0] r_readsel2;
    logic [DATA_W-1:0] r_hold_a;
    logic [DATA_W-1:0] r_hold_b;

    logic              w_handshake;
    pair_t             w_k_next;

    assign w_handshake = r_out_valid & stream.out_ready;
    assign w_k_next    = r_k + pair_t'(1);

    assign busy             = r_busy;
    assign done             = r_done;
    assign readsel1         = r_readsel1;
    assign readsel2         = r_readsel2;
    assign stream.out_valid = r_out_valid;
    assign stream.out_data  = r_out_data;
    assign stream.out_index = r_out_index;
    assign stream.out_last  = r_out_last;

    // Dump FSM with pair counter, snapshot registers and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_k         <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_out_data  <= '0;
            r_out_index <= '0;
            r_readsel1  <= '0;
            r_readsel2  <= '0;
            r_hold_a    <= '0;
            r_hold_b    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_k        <= '0;
                        r_busy     <= 1'b1;
                        r_readsel1 <= pair_index(pair_t'(0), 1'b0);
                        r_readsel2 <= pair_index(pair_t'(0), 1'b1);
                        r_state    <= READ;
                    end else begin
                        r_busy     <= 1'b0;
                        r_readsel1 <= '0;
                        r_readsel2 <= '0;
                        r_state    <= IDLE;
                    end
                end
                // The pair is frozen here; later writes only reach later pairs.
                READ: begin
                    r_hold_a    <= Dout1;
                    r_hold_b    <= Dout2;
                    r_out_valid <= 1'b1;
                    r_out_data  <= Dout1;
                    r_out_index <= r_readsel1;
                    r_out_last  <= (r_readsel1 == LAST_INDEX);
                    r_state     <= SEND_A;
                end
                SEND_A: begin
                    if (w_handshake) begin
                        r_out_data  <= r_hold_b;
                        r_out_index <= r_readsel2;
                        r_out_last  <= (r_readsel2 == LAST_INDEX);
                        r_state     <= SEND_B;
                    end else begin
                        r_state     <= SEND_A;
                    end
                end
                SEND_B: begin
                    if (w_handshake) begin
                        r_out_valid <= 1'b0;
                        r_out_last  <= 1'b0;
                        if (r_k == LAST_PAIR) begin
                            r_done     <= 1'b1;
                            r_readsel1 <= '0;
                            r_readsel2 <= '0;
                            r_state    <= DONE;
                        end else begin
                            r_k        <= w_k_next;
                            r_readsel1 <= pair_index(w_k_next, 1'b0);
                            r_readsel2 <= pair_index(w_k_next, 1'b1);
                            r_state    <= READ;
                        end
                    end else begin
                        r_state <= SEND_B;
                    end
                end
                DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_busy      <= 1'b0;
                    r_done      <= 1'b0;
                    r_out_valid <= 1'b0;
                    r_out_last  <= 1'b0;
                    r_readsel1  <= '0;
                    r_readsel2  <= '0;
                    r_state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_dump.sv
// Directed self-checking bench for regfile_dump with a behavioural register file.
module tb_regfile_dump;
    import regfile_pkg::*;

    logic              clk;
    logic              rst_n;
    logic              start;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] readsel1;
    logic [ADDR_W-1:0] readsel2;
    logic [DATA_W-1:0] Dout1;
    logic [DATA_W-1:0] Dout2;
    logic [DATA_W-1:0] regs [32];

    regfile_dump_if sif ();

    regfile_dump dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .busy     (busy),
        .done     (done),
        .readsel1 (readsel1),
        .readsel2 (readsel2),
        .Dout1    (Dout1),
        .Dout2    (Dout2),
        .stream   (sif)
    );

    assign Dout1 = regs[readsel1];
    assign Dout2 = regs[readsel2];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cmp_cnt = 0;
    int err_cnt = 0;

    int                n_words;
    int                n_done;
    int                done_c [4];
    int                first_valid_c;
    int                stable_err;
    logic [ADDR_W-1:0] cap_idx  [128];
    logic [DATA_W-1:0] cap_data [128];
    logic              cap_last [128];

    // Hand-written expected register contents; after_snap adds r3/r5 writes.
    function automatic logic [31:0] exp_word(input int i, input bit after_snap);
        case (i)
            1:       return 32'h0000_8421;
            2:       return 32'h0000_1248;
            3:       return after_snap ? 32'h0000_CAFE : 32'h0;
            5:       return after_snap ? 32'h0000_BEEF : 32'h0;
            31:      return 32'hDEAD_BEEF;
            default: return 32'h0;
        endcase
    endfunction

    // Pulses start, then acts as consumer cycle by cycle (c counts edges after the start edge).
    task automatic run_dump(input int mode, input int extra_start_c, input bit hold_start,
                            input bit snap, input int want_dones, input int tail, input int budget);
        logic              prev_v, prev_r, prev_l, rdy;
        logic [DATA_W-1:0] prev_d;
        logic [ADDR_W-1:0] prev_i;
        int                tail_cnt;
        n_words = 0; n_done = 0; first_valid_c = -1; stable_err = 0; tail_cnt = 0;
        for (int j = 0; j < 4; j++) done_c[j] = -1;
        prev_v = 1'b0; prev_r = 1'b0; prev_l = 1'b0; prev_d = '0; prev_i = '0;
        start = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= budget; c++) begin
            @(negedge clk);
            start = hold_start || (c == extra_start_c);
            rdy = (mode == 0) ? 1'b1 : ((c % 2) == 1);
            sif.out_ready = rdy;
            if (snap && c == 5) regs[3] = 32'h0000_CAFE;
            if (snap && c == 6) regs[5] = 32'h0000_BEEF;
            if (prev_v && !prev_r) begin
                if (!sif.out_valid || sif.out_data !== prev_d || sif.out_index !== prev_i ||
                    sif.out_last !== prev_l) stable_err++;
            end
            if (sif.out_valid && first_valid_c < 0) first_valid_c = c;
            if (sif.out_valid && rdy) begin
                if (n_words < 128) begin
                    cap_idx[n_words]  = sif.out_index;
                    cap_data[n_words] = sif.out_data;
                    cap_last[n_words] = sif.out_last;
                end
                n_words++;
            end
            if (done) begin
                if (n_done < 4) done_c[n_done] = c;
                n_done++;
            end
            prev_v = sif.out_valid; prev_r = rdy; prev_d = sif.out_data;
            prev_i = sif.out_index; prev_l = sif.out_last;
            if (n_done >= want_dones) begin
                if (tail_cnt == tail) break;
                tail_cnt++;
            end
        end
        start = 1'b0;
        sif.out_ready = 1'b1;
    endtask

    task automatic idle_cycles(input int n);
        for (int j = 0; j < n; j++) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; sif.out_ready = 1'b0;
        idle_cycles(3);
        cmp_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL reset_busy: got %0b want 0", busy); end
        cmp_cnt++; if (done !== 1'b0) begin err_cnt++; $display("FAIL reset_done: got %0b want 0", done); end
        cmp_cnt++; if (sif.out_valid !== 1'b0) begin err_cnt++; $display("FAIL reset_valid: got %0b want 0", sif.out_valid); end
        cmp_cnt++; if (sif.out_data !== 32'h0) begin err_cnt++; $display("FAIL reset_data: got %0h want 0", sif.out_data); end
        cmp_cnt++; if (sif.out_index !== 5'd0) begin err_cnt++; $display("FAIL reset_index: got %0d want 0", sif.out_index); end
        cmp_cnt++; if (sif.out_last !== 1'b0) begin err_cnt++; $display("FAIL reset_last: got %0b want 0", sif.out_last); end
        cmp_cnt++; if (readsel1 !== 5'd0 || readsel2 !== 5'd0) begin
            err_cnt++; $display("FAIL reset_readsel: got %0d/%0d want 0/0", readsel1, readsel2); end
        rst_n = 1'b1;
        sif.out_ready = 1'b1;
        idle_cycles(2);
        cmp_cnt++; if (busy !== 1'b0 || sif.out_valid !== 1'b0) begin
            err_cnt++; $display("FAIL idle_after_reset: busy=%0b valid=%0b want 0/0", busy, sif.out_valid); end
    endtask

    task automatic check_dump(input string tag, input bit after_snap, input bit snap_case);
        logic [31:0] e;
        cmp_cnt++; if (n_words !== 32) begin err_cnt++; $display("FAIL %s_words: got %0d want 32", tag, n_words); end
        for (int i = 0; i < 32; i++) begin
            e = (snap_case && i == 5) ? 32'h0000_BEEF : exp_word(i, after_snap);
            cmp_cnt++; if (cap_idx[i] !== 5'(i)) begin
                err_cnt++; $display("FAIL %s_index%0d: got %0d want %0d", tag, i, cap_idx[i], i); end
            cmp_cnt++; if (cap_data[i] !== e) begin
                err_cnt++; $display("FAIL %s_data%0d: got %0h want %0h", tag, i, cap_data[i], e); end
            cmp_cnt++; if (cap_last[i] !== (i == 31)) begin
                err_cnt++; $display("FAIL %s_last%0d: got %0b want %0b", tag, i, cap_last[i], i == 31); end
        end
        cmp_cnt++; if (n_done !== 1) begin err_cnt++; $display("FAIL %s_done_count: got %0d want 1", tag, n_done); end
    endtask

    task automatic test_full_dump();
        for (int i = 0; i < 32; i++) regs[i] = 32'h0;
        regs[1] = 32'h0000_8421; regs[2] = 32'h0000_1248; regs[31] = 32'hDEAD_BEEF;
        run_dump(0, -1, 1'b0, 1'b0, 1, 4, 200);
        check_dump("full", 1'b0, 1'b0);
        cmp_cnt++; if (first_valid_c !== 2) begin err_cnt++; $display("FAIL full_latency: got %0d want 2", first_valid_c); end
        cmp_cnt++; if (done_c[0] !== 49) begin err_cnt++; $display("FAIL full_done_cycle: got %0d want 49", done_c[0]); end
        cmp_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL full_busy_end: got %0b want 0", busy); end
    endtask

    task automatic test_stall();
        run_dump(1, -1, 1'b0, 1'b0, 1, 4, 300);
        check_dump("stall", 1'b0, 1'b0);
        cmp_cnt++; if (stable_err !== 0) begin err_cnt++; $display("FAIL stall_stable: got %0d unstable cycles want 0", stable_err); end
        cmp_cnt++; if (done_c[0] !== 66) begin err_cnt++; $display("FAIL stall_done_cycle: got %0d want 66", done_c[0]); end
    endtask

    task automatic test_snapshot();
        run_dump(0, -1, 1'b0, 1'b1, 1, 4, 200);
        check_dump("snap", 1'b0, 1'b1);
    endtask

    task automatic test_start_ignored();
        run_dump(0, 10, 1'b0, 1'b0, 1, 8, 200);
        check_dump("ignored", 1'b1, 1'b0);
        cmp_cnt++; if (done_c[0] !== 49) begin err_cnt++; $display("FAIL ignored_done_cycle: got %0d want 49", done_c[0]); end
    endtask

    task automatic test_reset_mid();
        bit found;
        bit activity;
        found = 1'b0; activity = 1'b0;
        start = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            start = 1'b0;
            sif.out_ready = 1'b1;
            if (sif.out_valid && sif.out_index == 5'd10) begin found = 1'b1; break; end
        end
        cmp_cnt++; if (!found) begin err_cnt++; $display("FAIL rstmid_reach10: got not-found want index 10"); end
        rst_n = 1'b0;
        #1;
        cmp_cnt++; if (sif.out_valid !== 1'b0) begin err_cnt++; $display("FAIL rstmid_valid: got %0b want 0", sif.out_valid); end
        cmp_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL rstmid_busy: got %0b want 0", busy); end
        cmp_cnt++; if (readsel1 !== 5'd0 || readsel2 !== 5'd0) begin
            err_cnt++; $display("FAIL rstmid_readsel: got %0d/%0d want 0/0", readsel1, readsel2); end
        idle_cycles(2);
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (done || sif.out_valid || busy) activity = 1'b1;
        end
        cmp_cnt++; if (activity) begin err_cnt++; $display("FAIL rstmid_no_done: got activity want none"); end
        run_dump(0, -1, 1'b0, 1'b0, 1, 4, 200);
        check_dump("restart", 1'b1, 1'b0);
    endtask

    task automatic test_back_to_back();
        run_dump(0, -1, 1'b1, 1'b0, 2, 0, 300);
        cmp_cnt++; if (n_words !== 64) begin err_cnt++; $display("FAIL b2b_words: got %0d want 64", n_words); end
        for (int i = 0; i < 64; i++) begin
            cmp_cnt++; if (cap_idx[i] !== 5'(i % 32) || cap_data[i] !== exp_word(i % 32, 1'b1)) begin
                err_cnt++; $display("FAIL b2b_word%0d: got %0d/%0h want %0d/%0h", i, cap_idx[i], cap_data[i],
                                    i % 32, exp_word(i % 32, 1'b1)); end
        end
        cmp_cnt++; if (done_c[0] !== 49) begin err_cnt++; $display("FAIL b2b_done1: got %0d want 49", done_c[0]); end
        cmp_cnt++; if (done_c[1] !== 99) begin err_cnt++; $display("FAIL b2b_done2: got %0d want 99", done_c[1]); end
        idle_cycles(3);
        cmp_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL b2b_idle: got busy %0b want 0", busy); end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) regs[i] = 32'h0;
        test_reset();
        test_full_dump();
        idle_cycles(2);
        test_stall();
        idle_cycles(2);
        test_snapshot();
        idle_cycles(2);
        test_start_ignored();
        idle_cycles(2);
        test_reset_mid();
        idle_cycles(2);
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
